bcd_display_sequencer: RTL and testbench

Sequences the 12-bit counter value through the shared serial `bin2bcd` converter and drives the four-digit multiplexed seven-segment display from the latched BCD result. It sits between the free-running counter and the display pins in the `Lab_8` top level. It owns the converter's `en`/`ready` handshake, the periodic sampling cadence, conversion timeout recovery and digit refresh.

---
 rtl/bcd_display_sequencer.sv | 161 ++++++++++++++++
 tb/tb_bcd_display_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_sequencer
// Description : Samples a 12-bit value through a serial bin2bcd converter
//               (en/ready handshake with timeout) and multiplexes the BCD
//               result onto a 4-digit seven-segment display.
//               Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_sequencer #(
    parameter int UPDATE_PERIOD = 1000,
    parameter int REFRESH_DIV   = 250,
    parameter int CONV_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [11:0] value_in,
    output logic        conv_en,
    output logic [11:0] conv_bin,
    input  logic [15:0] conv_bcd,
    input  logic        conv_ready,
    output logic [3:0]  anode,
    output logic [6:0]  cathode,
    output logic        busy,
    output logic        timeout_err
);

    localparam int c_PER_W = $clog2(UPDATE_PERIOD);
    localparam int c_DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_TMR_W = $clog2(CONV_TIMEOUT + 1);

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_LOAD    = 2'd1;
    localparam logic [1:0] c_S_CONVERT = 2'd2;
    localparam logic [1:0] c_S_LATCH   = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_PER_W-1:0] r_per_cnt;
    logic               r_pending;
    logic [c_TMR_W-1:0] r_timer;
    logic [15:0]        r_disp;
    logic [c_DIV_W-1:0] r_div;
    logic [1:0]         r_idx;

    logic               w_per_expire;
    logic               w_ready_ok;
    logic               w_conv_timeout;
    logic [3:0]         w_nib;
    logic [6:0]         w_glyph;
    logic               w_blank;

    assign w_per_expire   = (r_per_cnt == c_PER_W'(UPDATE_PERIOD - 1));
    // The first CONVERT cycle has timer==0; a ready seen then is stale.
    assign w_ready_ok     = (r_state == c_S_CONVERT) && (r_timer != '0) && conv_ready;
    assign w_conv_timeout = (r_state == c_S_CONVERT) && !w_ready_ok &&
                            (r_timer == c_TMR_W'(CONV_TIMEOUT - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:    if (w_per_expire || r_pending) w_state_nxt = c_S_LOAD;
            c_S_LOAD:    w_state_nxt = c_S_CONVERT;
            c_S_CONVERT: begin
                if (w_ready_ok)          w_state_nxt = c_S_LATCH;
                else if (w_conv_timeout) w_state_nxt = c_S_IDLE;
            end
            c_S_LATCH:   w_state_nxt = c_S_IDLE;
            default:     w_state_nxt = c_S_IDLE;
        endcase
    end

    assign w_nib = r_disp[{r_idx, 2'b00} +: 4];

    always_comb begin
        case (w_nib)
            4'd0:    w_glyph = 7'b1000000;
            4'd1:    w_glyph = 7'b1111001;
            4'd2:    w_glyph = 7'b0100100;
            4'd3:    w_glyph = 7'b0110000;
            4'd4:    w_glyph = 7'b0011001;
            4'd5:    w_glyph = 7'b0010010;
            4'd6:    w_glyph = 7'b0000010;
            4'd7:    w_glyph = 7'b1111000;
            4'd8:    w_glyph = 7'b0000000;
            4'd9:    w_glyph = 7'b0010000;
            default: w_glyph = 7'b0111111;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is leading-zero when it and every more significant nibble is 0.
    always_comb begin
        case (r_idx)
            2'd3:    w_blank = (r_disp[15:12] == 4'd0);
            2'd2:    w_blank = (r_disp[15:8]  == 8'd0);
            2'd1:    w_blank = (r_disp[15:4]  == 12'd0);
            default: w_blank = 1'b0;
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state     <= c_S_IDLE;
            r_per_cnt   <= '0;
            r_pending   <= 1'b0;
            r_timer     <= '0;
            r_disp      <= 16'h0000;
            r_div       <= '0;
            r_idx       <= 2'd0;
            conv_en     <= 1'b0;
            conv_bin    <= 12'd0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            anode       <= 4'b1111;
            cathode     <= 7'b1111111;
        end else begin
            r_state   <= w_state_nxt;
            r_per_cnt <= w_per_expire ? '0 : r_per_cnt + c_PER_W'(1);

            // Expiries outside IDLE are remembered so the cadence never slips.
            if (r_state == c_S_IDLE)
                r_pending <= 1'b0;
            else if (w_per_expire)
                r_pending <= 1'b1;

            conv_en <= (w_state_nxt == c_S_CONVERT);
            busy    <= (w_state_nxt != c_S_IDLE);

            if (r_state == c_S_LOAD) begin
                conv_bin <= value_in;
                r_timer  <= '0;
            end else if (r_state == c_S_CONVERT) begin
                r_timer  <= r_timer + c_TMR_W'(1);
            end

            if (r_state == c_S_LATCH) begin
                r_disp      <= conv_bcd;
                timeout_err <= 1'b0;
            end else if (w_conv_timeout) begin
                r_disp      <= 16'hFFFF;
                timeout_err <= 1'b1;
            end

            if (r_div == c_DIV_W'(REFRESH_DIV - 1)) begin
                r_div <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_div <= r_div + c_DIV_W'(1);
            end

            anode   <= ~(4'b0001 << r_idx);
            cathode <= w_blank ? 7'b1111111 : w_glyph;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_display_sequencer
// Description : Self-checking bench with a behavioural bin2bcd converter and
//               a decimal-arithmetic display model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_display_sequencer;

    localparam int UP = 100;
    localparam int RD = 4;
    localparam int TO = 64;

    logic        clk        = 1'b0;
    logic        RST        = 1'b1;
    logic [11:0] value_in   = 12'd0;
    logic        conv_en;
    logic [11:0] conv_bin;
    logic [15:0] conv_bcd   = 16'h0000;
    logic        conv_ready = 1'b0;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic        busy;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_rise = 0;
    int cv_delay = 14;
    int cv_mode = 0;   // 0: ready after cv_delay, 1: stale first-cycle ready too, 2: never
    int en_cnt = 0;
    int disp_val = 0;
    bit disp_dash = 1'b0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};
    int p10 [4] = '{1, 10, 100, 1000};

    bcd_display_sequencer #(
        .UPDATE_PERIOD(UP),
        .REFRESH_DIV  (RD),
        .CONV_TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .value_in   (value_in),
        .conv_en    (conv_en),
        .conv_bin   (conv_bin),
        .conv_bcd   (conv_bcd),
        .conv_ready (conv_ready),
        .anode      (anode),
        .cathode    (cathode),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural converter: en_cnt is the index of the current en-high cycle.
    always @(negedge clk) begin
        if (conv_en === 1'b1) en_cnt = en_cnt + 1;
        else                  en_cnt = 0;
        case (cv_mode)
            0:       conv_ready = (conv_en === 1'b1) && (en_cnt >= cv_delay);
            1:       conv_ready = (conv_en === 1'b1) && (en_cnt == 1 || en_cnt >= cv_delay);
            default: conv_ready = 1'b0;
        endcase
        conv_bcd = {4'(conv_bin / 1000), 4'((conv_bin / 100) % 10),
                    4'((conv_bin / 10) % 10), 4'(conv_bin % 10)};
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] exp_seg(input int i);
        if (disp_dash) return 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && disp_val < p10[i]) return 7'b1111111;
`endif
        return seg_tab[(disp_val / p10[i]) % 10];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic scan_display(input string tag);
        int idx;
        logic [3:0] seen;
        logic [3:0] onehot;
        seen = 4'b0000;
        for (int k = 0; k < 4 * RD; k++) begin
            idx = -1;
            for (int i = 0; i < 4; i++) begin
                onehot = ~(4'b0001 << i);
                if (anode === onehot) idx = i;
            end
            chk({tag, "_anode_valid"}, (idx >= 0), 1);
            if (idx >= 0) begin
                seen[idx] = 1'b1;
                chk({tag, "_cathode"}, cathode, exp_seg(idx));
            end
            @(negedge clk);
        end
        chk({tag, "_digits_seen"}, seen, 4'hF);
    endtask

    task automatic wait_load(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b1 && n < UP + 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_load_seen"}, (busy === 1'b1), 1);
        chk({tag, "_period"}, cyc - last_rise, UP);
        last_rise = cyc;
        chk({tag, "_load_en"}, conv_en, 0);
    endtask

    task automatic conv(input string tag, input int val, input int delay, input int mode);
        int  n;
        bit  bin_ok;
        bit  tmo;
        value_in = 12'(val);
        cv_delay = delay;
        cv_mode  = mode;
        tmo      = (mode == 2);
        wait_load(tag);
        n = 0;
        bin_ok = 1'b1;
        @(negedge clk);
        while (conv_en === 1'b1 && n < TO + 10) begin
            if (conv_bin !== 12'(val)) bin_ok = 1'b0;
            n++;
            @(negedge clk);
        end
        chk({tag, "_convert_cycles"}, n, tmo ? TO : delay);
        chk({tag, "_bin_hold"}, bin_ok, 1);
        chk({tag, "_busy_after_convert"}, busy, tmo ? 0 : 1);
        if (tmo) disp_dash = 1'b1;
        else begin
            disp_dash = 1'b0;
            disp_val  = val;
        end
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_timeout_err"}, timeout_err, tmo);
        chk({tag, "_busy_idle"}, busy, 0);
        scan_display(tag);
    endtask

    initial begin
        logic [3:0] exp_an;
        int v;

        value_in = 12'd3215;
        repeat (5) @(negedge clk);
        chk("rst_conv_en", conv_en, 0);
        chk("rst_conv_bin", conv_bin, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_anode", anode, 4'b1111);
        chk("rst_cathode", cathode, 7'b1111111);

        RST = 1'b0;
        last_rise = cyc;
        for (int k = 1; k <= 4 * RD; k++) begin
            @(negedge clk);
            exp_an = ~(4'b0001 << ((k - 1) / RD));
            chk("post_rst_anode", anode, exp_an);
            chk("post_rst_cathode", cathode, exp_seg((k - 1) / RD));
            chk("post_rst_busy", busy, 0);
        end

        conv("c3215", 3215, 14, 0);
        conv("timeout1", int'($urandom_range(4095)), 5, 2);
        conv("c1123", 1123, int'($urandom_range(20, 2)), 0);
        conv("timeout2", int'($urandom_range(4095)), 5, 2);

        // Reset pulse in the middle of a conversion.
        value_in = 12'($urandom_range(4095));
        cv_delay = 10;
        cv_mode  = 0;
        wait_load("midrst");
        @(negedge clk);
        @(negedge clk);
        chk("midrst_in_convert", conv_en, 1);
        RST = 1'b1;
        @(negedge clk);
        chk("midrst_conv_en", conv_en, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_timeout_err", timeout_err, 0);
        chk("midrst_conv_bin", conv_bin, 0);
        chk("midrst_anode", anode, 4'b1111);
        chk("midrst_cathode", cathode, 7'b1111111);
        RST = 1'b0;
        last_rise = cyc;
        disp_val  = 0;
        disp_dash = 1'b0;
        conv("post_midrst", int'($urandom_range(4095)), 5, 0);

        conv("stale_ready", int'($urandom_range(4095)), 6, 1);
        conv("val7", 7, int'($urandom_range(20, 2)), 0);
        conv("val42", 42, int'($urandom_range(20, 2)), 0);
        conv("val0", 0, 2, 0);
        for (int r = 0; r < 4; r++) begin
            v = int'($urandom_range(4095));
            conv("random", v, int'($urandom_range(20, 2)), int'($urandom_range(1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
